div8u4_seq: RTL and testbench
=============================

// Module: div8u4_seq
// PURPOSE
//  Sequential unsigned 2N/N restoring divider, the inverse of the 4x4 unsigned multiplier family:
//  it accepts a 2N-bit product and an N-bit divisor and returns the N-bit quotient and remainder.
//  A built-in residue self-check recomputes q*d+r and flags any mismatch caused by internal faults.
//  It is used where a product has to be decomposed back into its factors.
// PARAMETERS
//  N         4   divisor/quotient/remainder width; dividend width is 2N
//  CHECK_EN  1   1: run the q*d+r==dividend self-check cycle; 0: skip CHECK, chk_err_o tied 0
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  start_i      in   1   request; sampled only in IDLE
//  dividend_i   in   2N  unsigned dividend, captured with start_i
//  divisor_i    in   N   unsigned divisor, captured with start_i
//  busy_o       out  1   high from the cycle after start is accepted until done_o
//  done_o       out  1   one-cycle completion pulse
//  quotient_o   out  N   result quotient, held until the next accepted start
//  remainder_o  out  N   result remainder, held until the next accepted start
//  dbz_o        out  1   divide-by-zero flag, valid with done_o and held
//  ovf_o        out  1   quotient-overflow flag (dividend[2N-1:N] >= divisor), valid with done_o and held
//  chk_err_o    out  1   self-check mismatch flag, valid with done_o and held
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; internal registers 0. Reset mid-operation aborts with no done_o.
//  FSM: IDLE -> CALC (N cycles) -> CHECK (1 cycle, skipped if CHECK_EN=0) -> DONE (1 cycle) -> IDLE.
//  Accept: in IDLE with start_i=1, capture operands and clear the flags. start_i outside IDLE is ignored.
//  Fast path at capture:
//   - divisor==0: next state DONE; dbz_o=1, quotient=all ones, remainder=dividend[N-1:0].
//   - otherwise, if dividend[2N-1:N] >= divisor: next state DONE; ovf_o=1, quotient=all ones, remainder=0.
//   - dbz takes priority over ovf. chk_err_o=0 on both fast paths.
//  CALC: partial remainder R is N+1 bits wide, initialised to dividend[2N-1:N]. Each step:
//   - R = {R[N-1:0], next dividend bit, MSB first};
//   - if R >= d, then R = R - d and the quotient bit is 1, else the quotient bit is 0.
//   - One quotient bit per cycle, MSB first. After N steps, R[N-1:0] is the remainder.
//  CHECK: chk_err = ({N'b0,q}*d + r != dividend), computed in 2N bits with no truncation.
//  DONE: done_o=1 for exactly one cycle. quotient_o, remainder_o and the flags update in this cycle.
//  Latency, measured in edges from the edge that samples start_i to the edge that raises done_o:
//   - N+2 with CHECK_EN=1;
//   - N+1 with CHECK_EN=0;
//   - 1 on either fast path.
//  busy_o is low in IDLE and in DONE. A new start can be accepted in the cycle after done_o.
//  No internal arithmetic wraps: R never exceeds 2d-1 < 2^(N+1).
// STRUCTURE
//  Shared package/include: state encodings (IDLE, CALC, CHECK, DONE), width localparams (N, 2N),
//  and the step counter width $clog2(N+1).
//  Sub-module: mult_nxn_u, a combinational NxN unsigned multiplier with a 2N-bit product from the
//  multiplier family. It is instantiated once for the CHECK cycle; the adder and comparator stay
//  in the top level.
// TESTING
//  1) Divide: 200/13 -> done after 6 edges; q=15, r=5; dbz=ovf=chk_err=0; busy_o high for cycles 1..5.
//  2) Exhaustive: every dividend < (divisor<<4), divisor 1..15 -> q,r match the reference model; chk_err=0.
//  3) Divide-by-zero: 0xF0/0 -> done after 1 edge; dbz=1, ovf=0, q=0xF, r=0x0.
//  4) Overflow: 0x50/5 -> ovf=1, q=0xF, r=0.
//     Also 0x4F/5 -> q=0xF, r=4, ovf=0.
//  5) Control: start_i held high through a whole operation -> only one op runs.
//     rst_n low in CALC step 2 -> outputs 0, no done_o; the next op is correct.
//  6) Fault injection: force the CALC quotient bit 0 during 225/15 -> chk_err_o=1 with done_o.
//     Release the force and rerun -> q=15, r=0, chk_err=0.

Source files
------------

// File: rtl/div8u4_seq_pkg.sv
// Shared definitions for the div8u4_seq divider.
// Contents: default widths, the FSM state encoding and a step-counter width helper.
package div8u4_seq_pkg;

    localparam int DIV_N  = 4;            // divisor / quotient / remainder width
    localparam int DIV_W2 = 2 * DIV_N;    // dividend width
    localparam int DIV_CW = $clog2(DIV_N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Step counter width for an n-step divide.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div8u4_seq_if.sv
// Request/result bundle of the divider.
//   master: drives start_i, dividend_i, divisor_i; observes results.
//   slave : the divider; drives busy_o, done_o, quotient_o, remainder_o,
//           dbz_o, ovf_o, chk_err_o.
interface div8u4_seq_if
    import div8u4_seq_pkg::*;
#(
    parameter int N = DIV_N
);
    logic             start_i;
    logic [2*N-1:0]   dividend_i;
    logic [N-1:0]     divisor_i;
    logic             busy_o;
    logic             done_o;
    logic [N-1:0]     quotient_o;
    logic [N-1:0]     remainder_o;
    logic             dbz_o;
    logic             ovf_o;
    logic             chk_err_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, dbz_o, ovf_o, chk_err_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, dbz_o, ovf_o, chk_err_o
    );
endinterface

// File: rtl/div8u4_seq_mult.sv
// mult_nxn_u: combinational NxN unsigned multiplier, full 2N-bit product.
//   a_i, b_i : N-bit unsigned factors
//   p_o      : 2N-bit product
module mult_nxn_u
    import div8u4_seq_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);
    assign p_o = (2*N)'(a_i) * (2*N)'(b_i);
endmodule

// File: rtl/div8u4_seq.sv
// div8u4_seq: sequential unsigned 2N/N restoring divider with residue self-check.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of div8u4_seq_if (start/operands in, results/flags out)
// One quotient bit per CALC cycle, MSB first; an optional CHECK cycle recomputes
// q*d+r and flags a mismatch. Results and flags are published as done_o rises.
module div8u4_seq
    import div8u4_seq_pkg::*;
#(
    parameter int N        = DIV_N,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    div8u4_seq_if.slave  bus
);
    localparam int CW = cnt_w(N);

    state_t          state_q;
    logic [2*N-1:0]  dvd_q;     // full dividend kept for the self-check
    logic [N-1:0]    d_q;
    logic [N-1:0]    lo_q;      // low dividend half, shifted out MSB first
    logic [N:0]      r_q;       // partial remainder
    logic [N-1:0]    q_q;
    logic [CW-1:0]   cnt_q;
    logic            dbz_q, ovf_q, chk_q;

    logic [N:0]      sh, diff, r_step;
    logic            q_bit;
    logic [2*N-1:0]  prod;
    logic [2*N:0]    sum;
    logic            chk_mis;

    // Shift in the next dividend bit, then restore-or-subtract.
    assign sh     = {r_q[N-1:0], lo_q[N-1]};
    assign diff   = sh - {1'b0, d_q};
    assign q_bit  = (sh >= {1'b0, d_q});
    assign r_step = q_bit ? diff : sh;

    mult_nxn_u #(.N(N)) u_mult (
        .a_i (q_q),
        .b_i (d_q),
        .p_o (prod)
    );

    // One spare bit so the residue sum can never wrap.
    assign sum     = {1'b0, prod} + (2*N+1)'(r_q);
    assign chk_mis = (sum != {1'b0, dvd_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            dvd_q           <= '0;
            d_q             <= '0;
            lo_q            <= '0;
            r_q             <= '0;
            q_q             <= '0;
            cnt_q           <= '0;
            dbz_q           <= 1'b0;
            ovf_q           <= 1'b0;
            chk_q           <= 1'b0;
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.quotient_o  <= '0;
            bus.remainder_o <= '0;
            bus.dbz_o       <= 1'b0;
            bus.ovf_o       <= 1'b0;
            bus.chk_err_o   <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        dvd_q         <= bus.dividend_i;
                        d_q           <= bus.divisor_i;
                        lo_q          <= bus.dividend_i[N-1:0];
                        cnt_q         <= '0;
                        chk_q         <= 1'b0;
                        bus.dbz_o     <= 1'b0;
                        bus.ovf_o     <= 1'b0;
                        bus.chk_err_o <= 1'b0;
                        if (bus.divisor_i == '0) begin
                            dbz_q   <= 1'b1;
                            ovf_q   <= 1'b0;
                            q_q     <= '1;
                            r_q     <= {1'b0, bus.dividend_i[N-1:0]};
                            state_q <= S_DONE;
                        end else if (bus.dividend_i[2*N-1:N] >= bus.divisor_i) begin
                            // Quotient would not fit in N bits.
                            dbz_q   <= 1'b0;
                            ovf_q   <= 1'b1;
                            q_q     <= '1;
                            r_q     <= '0;
                            state_q <= S_DONE;
                        end else begin
                            dbz_q      <= 1'b0;
                            ovf_q      <= 1'b0;
                            q_q        <= '0;
                            r_q        <= {1'b0, bus.dividend_i[2*N-1:N]};
                            bus.busy_o <= 1'b1;
                            state_q    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_q   <= r_step;
                    q_q   <= {q_q[N-2:0], q_bit};
                    lo_q  <= {lo_q[N-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) begin
                        if (CHECK_EN) begin
                            state_q <= S_CHECK;
                        end else begin
                            bus.busy_o <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_CHECK: begin
                    chk_q      <= chk_mis;
                    bus.busy_o <= 1'b0;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    bus.done_o      <= 1'b1;
                    bus.quotient_o  <= q_q;
                    bus.remainder_o <= r_q[N-1:0];
                    bus.dbz_o       <= dbz_q;
                    bus.ovf_o       <= ovf_q;
                    bus.chk_err_o   <= chk_q;
                    state_q         <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div8u4_seq.sv
module tb_div8u4_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   lat, bcnt;

    div8u4_seq_if #(.N(4)) bus ();

    div8u4_seq #(.N(4), .CHECK_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request; lat = edges from the sampling edge to done_o,
    // bcnt = cycles with busy_o high in between. hold keeps start_i high until done.
    task automatic run_op(input logic [7:0] dvd, input logic [3:0] dvs, input bit hold,
                          output int l, output int b);
        @(negedge clk);
        bus.start_i    = 1'b1;
        bus.dividend_i = dvd;
        bus.divisor_i  = dvs;
        @(posedge clk); #1;
        if (!hold) bus.start_i = 1'b0;
        l = 0; b = 0;
        while (!bus.done_o && l < 40) begin
            if (bus.busy_o) b++;
            @(posedge clk); #1;
            l++;
        end
        bus.start_i = 1'b0;
        if (l >= 40) check("done_timeout", 32'(l), 32'd0);
    endtask

    initial begin
        bus.start_i    = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_q",    32'(bus.quotient_o), 0);
        check("rst_r",    32'(bus.remainder_o), 0);
        check("rst_flags", 32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 0);
        @(negedge clk) rst_n = 1'b1;

        // 200/13 = 15 r 5
        run_op(8'd200, 4'd13, 1'b0, lat, bcnt);
        check("div_lat",  32'(lat), 6);
        check("div_busy", 32'(bcnt), 5);
        check("div_q",    32'(bus.quotient_o), 15);
        check("div_r",    32'(bus.remainder_o), 5);
        check("div_flags", 32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 0);
        check("div_busy_at_done", 32'(bus.busy_o), 0);

        // Exhaustive non-overflow range against q = x/d, r = x%d.
        for (int d = 1; d < 16; d++) begin
            for (int x = 0; x < (d << 4); x++) begin
                run_op(8'(x), 4'(d), 1'b0, lat, bcnt);
                check($sformatf("exh_q %0d/%0d", x, d), 32'(bus.quotient_o), 32'(x / d));
                check($sformatf("exh_r %0d/%0d", x, d), 32'(bus.remainder_o), 32'(x % d));
                check($sformatf("exh_f %0d/%0d", x, d),
                      32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 0);
                check($sformatf("exh_lat %0d/%0d", x, d), 32'(lat), 6);
            end
        end

        // Divide by zero; dbz wins over ovf.
        run_op(8'hF0, 4'd0, 1'b0, lat, bcnt);
        check("dbz_lat",  32'(lat), 1);
        check("dbz_busy", 32'(bcnt), 0);
        check("dbz_q",    32'(bus.quotient_o), 15);
        check("dbz_r",    32'(bus.remainder_o), 0);
        check("dbz_flags", 32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 3'b100);
        run_op(8'h37, 4'd0, 1'b0, lat, bcnt);
        check("dbz2_r",   32'(bus.remainder_o), 7);
        check("dbz2_flags", 32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 3'b100);

        // Overflow boundary.
        run_op(8'h50, 4'd5, 1'b0, lat, bcnt);
        check("ovf_lat",  32'(lat), 1);
        check("ovf_q",    32'(bus.quotient_o), 15);
        check("ovf_r",    32'(bus.remainder_o), 0);
        check("ovf_flags", 32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 3'b010);
        run_op(8'h4F, 4'd5, 1'b0, lat, bcnt);
        check("novf_lat", 32'(lat), 6);
        check("novf_q",   32'(bus.quotient_o), 15);
        check("novf_r",   32'(bus.remainder_o), 4);
        check("novf_flags", 32'({bus.dbz_o, bus.ovf_o, bus.chk_err_o}), 0);

        // start_i held through an operation: one op, then quiet, results held.
        run_op(8'd100, 4'd7, 1'b1, lat, bcnt);
        check("hold_lat", 32'(lat), 6);
        check("hold_q",   32'(bus.quotient_o), 14);
        check("hold_r",   32'(bus.remainder_o), 2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("hold_no_restart", 32'({bus.busy_o, bus.done_o}), 0);
        end
        check("hold_q_kept", 32'(bus.quotient_o), 14);

        // Reset during CALC step 2 aborts with no done_o.
        @(negedge clk);
        bus.start_i = 1'b1; bus.dividend_i = 8'd200; bus.divisor_i = 4'd13;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_q",     32'(bus.quotient_o), 0);
        check("abort_r",     32'(bus.remainder_o), 0);
        check("abort_ctl",   32'({bus.busy_o, bus.done_o}), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(bus.done_o), 0);
        end
        @(negedge clk) rst_n = 1'b1;
        run_op(8'd200, 4'd13, 1'b0, lat, bcnt);
        check("post_rst_lat", 32'(lat), 6);
        check("post_rst_q",   32'(bus.quotient_o), 15);
        check("post_rst_r",   32'(bus.remainder_o), 5);

        // Stuck-at-0 quotient bit must trip the residue check.
        force dut.q_bit = 1'b0;
        run_op(8'd225, 4'd15, 1'b0, lat, bcnt);
        check("fault_lat", 32'(lat), 6);
        check("fault_chk", 32'(bus.chk_err_o), 1);
        check("fault_q",   32'(bus.quotient_o), 0);
        release dut.q_bit;
        run_op(8'd225, 4'd15, 1'b0, lat, bcnt);
        check("clean_q",   32'(bus.quotient_o), 15);
        check("clean_r",   32'(bus.remainder_o), 0);
        check("clean_chk", 32'(bus.chk_err_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
